// File: rtl/hack_serial_pkg.sv
// rtl/hack_serial_pkg.sv - shared definitions for the 16-bit Hack word serial link
package hack_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serial_state_t;

    localparam int   DATA_BITS      = 8;
    localparam int   BYTES_PER_WORD = 2;
    localparam logic IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/hack_baud_tick.sv
// rtl/hack_baud_tick.sv - bit-period timer; tick marks the last cycle of each bit
module hack_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int            W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/hack_word_tx.sv
// rtl/hack_word_tx.sv - sends each 16-bit Hack word as two 8N1 byte frames, low byte first
module hack_word_tx
    import hack_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        valid,
    output logic        ready,
    output logic        tx,
    output logic        busy
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_param
            $error("hack_word_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_BYTE = 1'(BYTES_PER_WORD - 1);

    serial_state_t state, next_state;
    logic [15:0]   shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          byte_idx_q, byte_idx_d;
    logic          tx_q, tx_d;
    logic          tick;

    hack_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (state != IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
        end else begin
            state      <= next_state;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        next_state = state;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        tx_d       = IDLE_LEVEL;
        case (state)
            IDLE: begin
                if (valid) begin
                    shift_d    = in;
                    next_state = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_cnt_d  = '0;
                    next_state = DATA;
                end
            end
            DATA: begin
                // after the low byte shifts out, the high byte sits in bits [7:0]
                if (tick) begin
                    shift_d   = {1'b0, shift_q[15:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = 1'b0;
                        next_state = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        next_state = START;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        // line level is registered from the upcoming state so tx never glitches
        case (next_state)
            START:   tx_d = ~IDLE_LEVEL;
            DATA:    tx_d = shift_d[0];
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = ~ready;
    assign tx    = tx_q;

endmodule

// File: tb/tb_hack_word_tx.sv
// tb/tb_hack_word_tx.sv - checks three hack_word_tx instances (2, 4, 16 clocks/bit) against a waveform model
module tb_hack_word_tx;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] in_word;
    logic        valid;
    logic        tx_w    [3];
    logic        ready_w [3];
    logic        busy_w  [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hack_word_tx #(.CLKS_PER_BIT(g == 0 ? 2 : (g == 1 ? 4 : 16))) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .in      (in_word),
            .valid   (valid),
            .ready   (ready_w[g]),
            .tx      (tx_w[g]),
            .busy    (busy_w[g])
        );
    end

    function automatic int cpb(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 16);
    endfunction

    // bit period idx of a whole word: start, b0..b7, stop, start, b8..b15, stop
    function automatic logic frame_bit(input logic [15:0] w, input int idx);
        if (idx == 0 || idx == 10) return 1'b0;
        if (idx == 9 || idx == 19) return 1'b1;
        if (idx < 9) return w[idx-1];
        return w[idx-3];
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, k, act, exp, $time);
    endtask

    int          rem   [3];
    logic [15:0] mword [3];

    always @(posedge clock or negedge reset_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) rem[k] <= 0;
            else if (rem[k] > 0) rem[k] <= rem[k] - 1;
            else if (valid) begin
                rem[k]   <= 20 * cpb(k);
                mword[k] <= in_word;
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            logic idle, etx;
            idle = (rem[k] == 0);
            etx  = idle ? 1'b1 : frame_bit(mword[k], (20 * cpb(k) - rem[k]) / cpb(k));
            chk("tx", k, 32'(tx_w[k]), 32'(etx));
            chk("ready", k, 32'(ready_w[k]), 32'(idle));
            chk("busy", k, 32'(busy_w[k]), 32'(!idle));
        end
    end

    logic st [0:99];
    logic sr [0:99];

    function automatic logic [15:0] decode();
        logic [15:0] w;
        for (int b = 0; b < 8; b++) begin
            w[b]   = st[(1 + b) * 4 + 2];
            w[8+b] = st[(11 + b) * 4 + 2];
        end
        return w;
    endfunction

    task automatic wait_idle();
        logic all_idle;
        all_idle = 1'b0;
        for (int i = 0; i < 1000 && !all_idle; i++) begin
            @(negedge clock);
            all_idle = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0);
        end
        chk("idle_wait", 0, 32'(all_idle), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic [0:19] seq;
        logic        quiet;
        int          start_len [3];
        int          done_at   [3];
        logic        seen_one  [3];

        reset_n = 1'b0;
        valid   = 1'b0;
        in_word = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (50) @(negedge clock);
        chk("rst_tx", 1, 32'(tx_w[1]), 32'd1);
        chk("rst_ready", 1, 32'(ready_w[1]), 32'd1);
        chk("rst_busy", 1, 32'(busy_w[1]), 32'd0);

        valid = 1'b1; in_word = 16'hA55A;
        for (int i = 0; i < 84; i++) begin
            @(negedge clock);
            if (i == 0) valid = 1'b0;
            st[i] = tx_w[1]; sr[i] = ready_w[1];
        end
        seq = 20'b0_01011010_1_0_10100101_1;
        for (int i = 0; i < 20; i++)
            for (int j = 0; j < 4; j++)
                chk("a55a_bit", i, 32'(st[i*4+j]), 32'(seq[i]));
        chk("a55a_busy79", 1, 32'(sr[79]), 32'd0);
        chk("a55a_ready80", 1, 32'(sr[80]), 32'd1);
        wait_idle();

        valid = 1'b1; in_word = 16'h0001;
        for (int i = 0; i < 82; i++) begin
            @(negedge clock);
            if (i == 0) in_word = 16'hFFFF;
            st[i] = tx_w[1]; sr[i] = ready_w[1];
            if (i == 81) valid = 1'b0;
        end
        chk("b2b_word1", 1, 32'(decode()), 32'h0001);
        chk("b2b_stop", 1, 32'(st[79]), 32'd1);
        chk("b2b_gap_tx", 1, 32'(st[80]), 32'd1);
        chk("b2b_gap_ready", 1, 32'(sr[80]), 32'd1);
        chk("b2b_start2_tx", 1, 32'(st[81]), 32'd0);
        chk("b2b_start2_ready", 1, 32'(sr[81]), 32'd0);
        wait_idle();

        valid = 1'b1; in_word = 16'h1234;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (i == 0) valid = 1'b0;
            if (i == 10) begin valid = 1'b1; in_word = 16'hDEAD; end
            if (i == 11) valid = 1'b0;
            st[i] = tx_w[1]; sr[i] = ready_w[1];
        end
        chk("busy_word", 1, 32'(decode()), 32'h1234);
        quiet = 1'b1;
        for (int i = 80; i < 100; i++) quiet = quiet & st[i] & sr[i];
        chk("busy_no_second", 1, 32'(quiet), 32'd1);
        wait_idle();

        valid = 1'b1; in_word = 16'h5A5A;
        for (int i = 0; i < 55; i++) begin
            @(negedge clock);
            if (i == 0) valid = 1'b0;
        end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("midrst_tx", k, 32'(tx_w[k]), 32'd1);
            chk("midrst_ready", k, 32'(ready_w[k]), 32'd1);
            chk("midrst_busy", k, 32'(busy_w[k]), 32'd0);
        end
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        valid = 1'b1; in_word = 16'h00FF;
        for (int i = 0; i < 84; i++) begin
            @(negedge clock);
            if (i == 0) valid = 1'b0;
            st[i] = tx_w[1]; sr[i] = ready_w[1];
        end
        chk("post_rst_word", 1, 32'(decode()), 32'h00FF);
        chk("post_rst_ready80", 1, 32'(sr[80]), 32'd1);
        wait_idle();

        for (int k = 0; k < 3; k++) begin
            start_len[k] = 0; done_at[k] = -1; seen_one[k] = 1'b0;
        end
        valid = 1'b1; in_word = 16'h8001;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (i == 0) valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (tx_w[k] == 1'b1) seen_one[k] = 1'b1;
                else if (!seen_one[k]) start_len[k]++;
                if (done_at[k] < 0 && ready_w[k]) done_at[k] = i;
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk("sweep_bit_period", k, 32'(start_len[k]), 32'(cpb(k)));
            chk("sweep_frame_len", k, 32'(done_at[k]), 32'(20 * cpb(k)));
        end
        wait_idle();

        repeat (3000) begin
            @(negedge clock);
            valid   = ($urandom_range(0, 3) == 0);
            in_word = 16'($urandom);
        end
        @(negedge clock);
        valid = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hack_word_tx.md
Name: hack_word_tx

Overview:
- Serial transmitter for 16-bit Hack words. Sends each word as two UART-style byte frames, low byte first.
- Sits between the Hack memory-mapped output path and an external serial pin. It is the sending end of the team's 16-bit word serial link.
- Accepts one word per valid/ready handshake, then shifts it out at a fixed bit period.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Legal range ≥ 2; elaboration fails otherwise.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in  input  16  word to transmit; sampled only on the accept cycle.
- valid  input  1  producer has a word on in.
- ready  output  1  transmitter idle and able to accept a word.
- tx  output  1  serial line; idle level 1.
- busy  output  1  frame in progress; equals ~ready.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, tx=1, ready=1, busy=0, counters=0, shift register=0. Takes effect immediately, including mid-frame. Any partial frame is abandoned with no completion.
- Accept: valid&&ready at a rising edge. The word is latched into a 16-bit shift register. ready drops to 0 from the next cycle. in/valid are ignored while ready=0.
- States:
  - IDLE: tx=1, ready=1.
  - START: tx=0.
  - DATA: tx=current bit.
  - STOP: tx=1.
- Each of START, DATA and STOP lasts exactly CLKS_PER_BIT cycles per bit, timed by the baud counter.
- Transitions:
  - IDLE→START on accept.
  - START→DATA after one bit period.
  - DATA→STOP after 8 bit periods. Bits go LSB first; the shift register shifts right by 1 per bit.
  - STOP→START if byte_idx==0; set byte_idx=1.
  - STOP→IDLE if byte_idx==1; clear byte_idx.
- Frame order: start, low byte b0..b7, stop, start, high byte b8..b15, stop. 20 bit periods total, i.e. 20*CLKS_PER_BIT cycles from the first start cycle.
- Latency: tx falls on the cycle after the accept edge.
- Completion: ready rises the cycle after the last stop-bit cycle.
- Back-to-back words:
  - If valid is held high, the next accept occurs in the first IDLE cycle.
  - Exactly one idle cycle (tx=1) separates consecutive words.
  - No idle cycle occurs between the two bytes of one word.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Held at 0 in IDLE.
- Bit counter: 3 bits, counts 0..7 in DATA, cleared on entry to DATA.
- tx is driven from a register (glitch-free), not decoded combinationally from state.
- The module never drops an accepted word and never accepts while busy.

Decomposition:
- Shared package hack_serial_pkg:
  - state encoding (IDLE, START, DATA, STOP; 2 bits)
  - DATA_BITS=8
  - BYTES_PER_WORD=2
  - IDLE_LEVEL=1'b1
- The future receiver uses the same package.
- One sub-module: hack_baud_tick.
  - Parameter CLKS_PER_BIT; ports clock, reset_n, run, tick.
  - tick pulses for one cycle at the end of each bit period while run=1.
  - Counter cleared while run=0.

Test Plan:
- Reset idle: CLKS_PER_BIT=4, reset_n=0 then 1, valid=0 for 50 cycles → tx=1, ready=1, busy=0 throughout.
- Single word: in=16'hA55A, valid for one cycle.
  - tx falls the next cycle; each bit is held 4 cycles.
  - Bit sequence: 0, 0,1,0,1,1,0,1,0, 1, 0, 1,0,1,0,0,1,0,1, 1.
  - ready returns to 1 exactly 80 cycles after tx first falls.
- Back-to-back: valid held high with in=16'h0001 then 16'hFFFF.
  - Two full frames are sent.
  - Exactly one tx=1 idle cycle separates them.
  - The second word is latched on the first ready cycle.
- Ignore while busy: during a frame for 16'h1234, pulse valid with in=16'hDEAD → waveform is only 16'h1234; no second frame follows.
- Reset mid-frame: assert reset_n=0 during DATA of the high byte.
  - tx=1 and ready=1 immediately, without waiting for a clock edge.
  - After release, a new word 16'h00FF transmits correctly from its start bit.
- Parameter sweep: CLKS_PER_BIT=2 and 16, in=16'h8001 → bit periods are exactly 2 and 16 cycles; total frame is 40 and 320 cycles.
